// File: rtl/dec_bpv_seq.sv
// Sequential BPV parser: walks the N_SUB 2x2 sub-blocks of one suffix window,
// one sub-block per beat, and reports the total BPV bits consumed per block.
module dec_bpv_seq #(
  parameter int BPV_BITS = 6,
  parameter int N_SUB    = 4,
  parameter int WIN_W    = 128,
  parameter int UW       = $clog2(WIN_W + 1),
  localparam int IW      = (N_SUB > 1) ? $clog2(N_SUB) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_fls,
  input  logic [N_SUB-1:0]    use2x2,
  input  logic [WIN_W-1:0]    suffix,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW-1:0]       out_sub_idx,
  output logic                out_is2x2,
  output logic [BPV_BITS-1:0] out_bpv0,
  output logic [BPV_BITS-1:0] out_bpv1,
  output logic                out_last,
  output logic                done,
  output logic [UW-1:0]       bits_used
);

  if (WIN_W < 2 * N_SUB * BPV_BITS) begin : g_bad_win
    $error("dec_bpv_seq: WIN_W must be >= 2*N_SUB*BPV_BITS");
  end

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   sr_q, sr_d;
  logic [N_SUB-1:0]   mask_q, mask_d;
  logic               fls_q, fls_d;
  logic [IW-1:0]      cnt_q, cnt_d;
  logic [UW-1:0]      acc_q, acc_d;
  logic               done_q, done_d;
  logic [UW-1:0]      bits_used_q, bits_used_d;

  logic [BPV_BITS-1:0] f0, f1;
  logic [UW-1:0]       bpb, consumed;
  logic                is2x2, last, hs, last_hs, accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      mask_q      <= '0;
      fls_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      bits_used_q <= '0;
    end else begin
      sr_q        <= sr_d;
      mask_q      <= mask_d;
      fls_q       <= fls_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      bits_used_q <= bits_used_d;
    end
  end

  // Field extraction; in FLS mode the field is one bit shorter and the
  // 2^(BPV_BITS-1) offset is just a forced MSB.
  always_comb begin
    if (fls_q) begin
      f0  = {1'b1, sr_q[WIN_W-1 -: BPV_BITS-1]};
      f1  = {1'b1, sr_q[WIN_W-BPV_BITS -: BPV_BITS-1]};
      bpb = UW'(BPV_BITS - 1);
    end else begin
      f0  = sr_q[WIN_W-1 -: BPV_BITS];
      f1  = sr_q[WIN_W-1-BPV_BITS -: BPV_BITS];
      bpb = UW'(BPV_BITS);
    end
    is2x2    = mask_q[cnt_q];
    consumed = is2x2 ? bpb : bpb + bpb;
    last     = (cnt_q == IW'(N_SUB - 1));
    hs       = (state_q == S_EMIT) && out_ready;
    last_hs  = hs && last;
    in_ready = (state_q == S_IDLE) || last_hs;
    accept   = in_valid && in_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_EMIT;
        else          state_d = S_IDLE;
      end
      S_EMIT: begin
        if (last_hs) state_d = in_valid ? S_EMIT : S_IDLE;
        else         state_d = S_EMIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; a reload on the final handshake wins over the shift
  always_comb begin
    sr_d        = sr_q;
    mask_d      = mask_q;
    fls_d       = fls_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    done_d      = last_hs;
    bits_used_d = last_hs ? acc_q + consumed : bits_used_q;
    if (accept) begin
      sr_d   = suffix;
      mask_d = use2x2;
      fls_d  = is_fls;
      cnt_d  = '0;
      acc_d  = '0;
    end else if (hs) begin
      sr_d  = sr_q << consumed;
      acc_d = acc_q + consumed;
      cnt_d = last ? '0 : cnt_q + IW'(1);
    end else begin
      sr_d = sr_q;
    end
  end

  // Outputs
  always_comb begin
    out_valid   = (state_q == S_EMIT);
    out_sub_idx = cnt_q;
    out_is2x2   = is2x2;
    out_bpv0    = f0;
    out_bpv1    = is2x2 ? '0 : f1;
    out_last    = last;
    done        = done_q;
    bits_used   = bits_used_q;
  end

endmodule

// File: tb/tb_dec_bpv_seq.sv
// Directed self-checking bench for dec_bpv_seq with hand-computed BPV beats.
module tb_dec_bpv_seq;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, is_fls, out_valid, out_ready;
  logic [3:0]   use2x2;
  logic [127:0] suffix;
  logic [1:0]   out_sub_idx;
  logic         out_is2x2, out_last, done;
  logic [5:0]   out_bpv0, out_bpv1;
  logic [7:0]   bits_used;

  int n_checks = 0;
  int n_fail   = 0;
  int e0[4], e1[4], e2[4];
  int ebits;

  localparam logic [127:0] SFX_2X2 = {6'd5, 6'd17, 6'd63, 6'd0, 104'hA5A5A5A5A5A5A5A5A5A5A5A5A5};
  localparam logic [127:0] SFX_FLS = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 88'h3C3C3C3C3C3C3C3C3C3C3C};
  localparam logic [127:0] SFX_MIX = {6'd9, 6'd42, 6'd7, 6'd33, 6'd1, 6'd62, 92'h0F0F0F0F0F0F0F0F0F0F0F0};

  always #5 clk = ~clk;

  dec_bpv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_fls(is_fls), .use2x2(use2x2), .suffix(suffix),
    .out_valid(out_valid), .out_ready(out_ready), .out_sub_idx(out_sub_idx),
    .out_is2x2(out_is2x2), .out_bpv0(out_bpv0), .out_bpv1(out_bpv1),
    .out_last(out_last), .done(done), .bits_used(bits_used)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mix();
    e0 = '{9, 42, 33, 1};
    e1 = '{0, 7, 0, 62};
    e2 = '{1, 0, 1, 0};
    ebits = 36;
  endtask

  task automatic check_beat(input int b);
    check_eq("out_valid", int'(out_valid), 1);
    check_eq("sub_idx", int'(out_sub_idx), b);
    check_eq("is2x2", int'(out_is2x2), e2[b]);
    check_eq("bpv0", int'(out_bpv0), e0[b]);
    check_eq("bpv1", int'(out_bpv1), e1[b]);
    check_eq("last", int'(out_last), (b == 3) ? 1 : 0);
  endtask

  // Present a block at cycle +1 offset, then check each beat; optional stall.
  task automatic run_block(input logic fls, input logic [3:0] mask,
                           input logic [127:0] sfx, input int stall_beat);
    in_valid = 1'b1; is_fls = fls; use2x2 = mask; suffix = sfx; out_ready = 1'b1;
    #1;
    check_eq("in_ready_accept", int'(in_ready), 1);
    tick();
    in_valid = 1'b0; is_fls = ~fls; use2x2 = ~mask; suffix = ~sfx;
    #1;
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          check_beat(b);
          check_eq("stall_in_ready", int'(in_ready), 0);
          tick();
        end
        out_ready = 1'b1;
        #1;
      end
      check_beat(b);
      tick();
      #1;
    end
    check_eq("done_pulse", int'(done), 1);
    check_eq("bits_used", int'(bits_used), ebits);
    check_eq("idle_valid", int'(out_valid), 0);
    tick();
    #1;
    check_eq("done_clear", int'(done), 0);
    check_eq("bits_hold", int'(bits_used), ebits);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; is_fls = 1'b0; use2x2 = 4'd0;
    suffix = 128'd0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_bits_used", int'(bits_used), 0);
    tick();

    e0 = '{5, 17, 63, 0}; e1 = '{0, 0, 0, 0}; e2 = '{1, 1, 1, 1}; ebits = 24;
    run_block(1'b0, 4'b1111, SFX_2X2, -1);

    e0 = '{33, 35, 37, 39}; e1 = '{34, 36, 38, 40}; e2 = '{0, 0, 0, 0}; ebits = 40;
    run_block(1'b1, 4'b0000, SFX_FLS, -1);

    set_mix();
    run_block(1'b0, 4'b0101, SFX_MIX, -1);
    run_block(1'b0, 4'b0101, SFX_MIX, 1);

    // Back-to-back: all-2x2 block followed immediately by the mixed block
    e0 = '{5, 17, 63, 0}; e1 = '{0, 0, 0, 0}; e2 = '{1, 1, 1, 1};
    in_valid = 1'b1; is_fls = 1'b0; use2x2 = 4'b1111; suffix = SFX_2X2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) begin
      check_beat(b);
      tick();
      #1;
    end
    check_beat(3);
    in_valid = 1'b1; use2x2 = 4'b0101; suffix = SFX_MIX;
    #1;
    check_eq("b2b_in_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0; suffix = 128'd0;
    #1;
    set_mix();
    check_eq("b2b_done_a", int'(done), 1);
    check_eq("b2b_bits_a", int'(bits_used), 24);
    check_beat(0);
    tick();
    #1;
    check_eq("b2b_done_once", int'(done), 0);
    for (int b = 1; b < 4; b++) begin
      check_beat(b);
      tick();
      #1;
    end
    check_eq("b2b_done_b", int'(done), 1);
    check_eq("b2b_bits_b", int'(bits_used), 36);
    tick();
    #1;
    check_eq("b2b_done_b_clear", int'(done), 0);
    tick();

    // Reset mid-block after two handshakes (cnt == 2)
    in_valid = 1'b1; is_fls = 1'b1; use2x2 = 4'b0000; suffix = SFX_FLS; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    check_eq("mid_sub_idx", int'(out_sub_idx), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", int'(out_valid), 0);
    check_eq("mid_rst_in_ready", int'(in_ready), 1);
    check_eq("mid_rst_done", int'(done), 0);
    check_eq("mid_rst_bits", int'(bits_used), 0);
    tick();
    #1;
    check_eq("mid_rst_no_done", int'(done), 0);
    tick();

    set_mix();
    run_block(1'b0, 4'b0101, SFX_MIX, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
